// File: rtl/uart_tx_arbiter_if.sv
// Byte-write and UART handshake bundle between the two harts, the arbiter and the transmitter.
// The arbiter takes the slave side; the CPU/UART environment takes the master side.
interface uart_tx_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_full;
    logic       a_drop;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_full;
    logic       b_drop;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_src;
    logic       i_ready;
    logic       idle;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, i_ready,
        output a_full, a_drop, b_full, b_drop, o_valid, o_data, o_src, idle
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, i_ready,
        input  a_full, a_drop, b_full, b_drop, o_valid, o_data, o_src, idle
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Merges hart A and hart B UART byte writes through per-hart FIFOs into one
// registered valid/ready byte stream with round-robin arbitration.
module uart_tx_arbiter_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_valid,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       drop,
    output logic       nonempty,
    output logic [7:0] head
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;

    // Full comes from the registered count, so a same-cycle pop never frees room for a push.
    assign full     = (count == FULL_COUNT);
    assign nonempty = (count != '0);
    assign push     = push_valid & ~full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_valid && full) begin
                drop <= 1'b1;
            end
        end
    end
endmodule

module uart_tx_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus
);
    logic       a_nonempty;
    logic       b_nonempty;
    logic [7:0] a_head;
    logic [7:0] b_head;
    logic       pop_a;
    logic       pop_b;
    logic       load_ok;
    logic       grant;
    logic       grant_b;
    logic       last;
    logic       o_valid_q;
    logic [7:0] o_data_q;
    logic       o_src_q;

    uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk        (clk),
        .reset      (reset),
        .push_valid (bus.a_valid),
        .push_data  (bus.a_data),
        .pop        (pop_a),
        .full       (bus.a_full),
        .drop       (bus.a_drop),
        .nonempty   (a_nonempty),
        .head       (a_head)
    );

    uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clk        (clk),
        .reset      (reset),
        .push_valid (bus.b_valid),
        .push_data  (bus.b_data),
        .pop        (pop_b),
        .full       (bus.b_full),
        .drop       (bus.b_drop),
        .nonempty   (b_nonempty),
        .head       (b_head)
    );

    assign load_ok = ~o_valid_q | bus.i_ready;

    // On contention the hart that did not win last time gets the slot (last = 1 means B).
    always_comb begin
        grant   = 1'b0;
        grant_b = 1'b0;
        if (load_ok) begin
            if (a_nonempty && b_nonempty) begin
                grant   = 1'b1;
                grant_b = ~last;
            end else if (a_nonempty) begin
                grant   = 1'b1;
            end else if (b_nonempty) begin
                grant   = 1'b1;
                grant_b = 1'b1;
            end
        end
    end

    assign pop_a = grant & ~grant_b;
    assign pop_b = grant & grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid_q <= 1'b0;
            o_data_q  <= 8'h00;
            o_src_q   <= 1'b0;
            last      <= 1'b1;
        end else if (grant) begin
            o_valid_q <= 1'b1;
            o_data_q  <= grant_b ? b_head : a_head;
            o_src_q   <= grant_b;
            last      <= grant_b;
        end else if (bus.i_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_src   = o_src_q;
    assign bus.idle    = ~a_nonempty & ~b_nonempty & ~o_valid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a queue-based reference model.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       m_ov, m_src, m_last, m_adrop, m_bdrop;
    logic [7:0] m_od;
    logic [8:0] xfer_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("o_valid", 32'(bus.o_valid), 32'(m_ov));
        check("o_data",  32'(bus.o_data),  32'(m_od));
        check("o_src",   32'(bus.o_src),   32'(m_src));
        check("a_full",  32'(bus.a_full),  32'(qa.size() == DEPTH));
        check("b_full",  32'(bus.b_full),  32'(qb.size() == DEPTH));
        check("a_drop",  32'(bus.a_drop),  32'(m_adrop));
        check("b_drop",  32'(bus.b_drop),  32'(m_bdrop));
        check("idle",    32'(bus.idle),    32'(qa.size() == 0 && qb.size() == 0 && !m_ov));
    endtask

    task automatic cyc(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic rdy, input logic rst);
        logic fa, fb, ga, gb;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.i_ready = rdy;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            m_ov = 0; m_od = 8'h00; m_src = 0; m_last = 1; m_adrop = 0; m_bdrop = 0;
        end else begin
            if (m_ov && rdy) xfer_log.push_back({m_src, m_od});
            fa = (qa.size() == DEPTH);
            fb = (qb.size() == DEPTH);
            ga = 0;
            gb = 0;
            if (!m_ov || rdy) begin
                if (qa.size() > 0 && qb.size() > 0) begin
                    if (m_last) ga = 1; else gb = 1;
                end else if (qa.size() > 0) ga = 1;
                else if (qb.size() > 0) gb = 1;
            end
            if (ga) begin
                m_od = qa.pop_front(); m_src = 0; m_ov = 1; m_last = 0;
            end else if (gb) begin
                m_od = qb.pop_front(); m_src = 1; m_ov = 1; m_last = 1;
            end else if (rdy) begin
                m_ov = 0;
            end
            if (av) begin
                if (fa) m_adrop = 1; else qa.push_back(ad);
            end
            if (bv) begin
                if (fb) m_bdrop = 1; else qb.push_back(bd);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0; bus.i_ready = 0;
        reset = 1;

        // Reset state
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        check("rst_idle", 32'(bus.idle), 32'd1);
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);

        // Single byte: visible two cycles after the write, for exactly one cycle
        xfer_log.delete();
        cyc(1, 8'h41, 0, 8'h00, 1, 0);
        check("t1_not_yet", 32'(bus.o_valid), 32'd0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        check("t1_valid", 32'(bus.o_valid), 32'd1);
        check("t1_data", 32'(bus.o_data), 32'h41);
        check("t1_src", 32'(bus.o_src), 32'd0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        check("t1_gone", 32'(bus.o_valid), 32'd0);
        check("t1_idle", 32'(bus.idle), 32'd1);
        check("t1_count", 32'(xfer_log.size()), 32'd1);

        // Collision from reset: A first, then B
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        xfer_log.delete();
        cyc(1, 8'h41, 1, 8'h42, 1, 0);
        idle_cycles(4, 1);
        check("t2_count", 32'(xfer_log.size()), 32'd2);
        if (xfer_log.size() >= 2) begin
            check("t2_first", 32'(xfer_log[0]), 32'h041);
            check("t2_second", 32'(xfer_log[1]), 32'h142);
        end

        // Fairness: four bytes per hart, alternating sources
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        xfer_log.delete();
        for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 0, 0);
        idle_cycles(12, 1);
        check("t3_count", 32'(xfer_log.size()), 32'd8);
        for (int i = 0; i < xfer_log.size() && i < 8; i++)
            check("t3_order", 32'(xfer_log[i]),
                  (i % 2 == 0) ? 32'h0A0 + 32'(i / 2) : 32'h1B0 + 32'(i / 2));

        // Backpressure: 18 writes into a stalled stream, 17 kept
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        xfer_log.delete();
        for (int i = 0; i < 18; i++) cyc(1, 8'h10 + 8'(i), 0, 8'h00, 0, 0);
        idle_cycles(2, 0);
        check("t4_full", 32'(bus.a_full), 32'd1);
        check("t4_drop", 32'(bus.a_drop), 32'd1);
        check("t4_stable", 32'(bus.o_data), 32'h10);
        idle_cycles(20, 1);
        check("t4_count", 32'(xfer_log.size()), 32'd17);
        for (int i = 0; i < xfer_log.size() && i < 17; i++)
            check("t4_order", 32'(xfer_log[i]), 32'h010 + 32'(i));

        // Full with same-cycle pop: the write is still dropped
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        xfer_log.delete();
        for (int i = 0; i < 17; i++) cyc(1, 8'h30 + 8'(i), 0, 8'h00, 0, 0);
        check("t5_full", 32'(bus.a_full), 32'd1);
        cyc(1, 8'hFF, 0, 8'h00, 1, 0);
        check("t5_drop", 32'(bus.a_drop), 32'd1);
        check("t5_not_full", 32'(bus.a_full), 32'd0);
        idle_cycles(20, 1);
        check("t5_count", 32'(xfer_log.size()), 32'd17);
        if (xfer_log.size() == 17) check("t5_last", 32'(xfer_log[16]), 32'h040);

        // Reset mid-stream clears queued bytes and the sticky drop
        for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 8'h00, 0, 0);
        xfer_log.delete();
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        check("t6_o_valid", 32'(bus.o_valid), 32'd0);
        check("t6_idle", 32'(bus.idle), 32'd1);
        check("t6_drop", 32'(bus.a_drop), 32'd0);
        idle_cycles(10, 1);
        check("t6_no_stale", 32'(xfer_log.size()), 32'd0);

        // Randomized traffic with alternating light and heavy backpressure
        for (int i = 0; i < 3000; i++) begin
            int thr;
            thr = ((i / 400) % 2 == 1) ? 2 : 8;
            cyc($urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 9) < thr,
                $urandom_range(0, 499) == 0);
            if (xfer_log.size() > 64) xfer_log.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
